// File: rtl/tdc_ctrl_pkg.sv
// Shared types and command byte constants for the TDC power-up sequencer.
// Command bytes are ASCII characters received from the UART.
package tdc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EN_LOW  = 2'd1,
        EN_HIGH = 2'd2,
        SRST    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_NONE     = 3'd0,
        C_BOOT_ALL = 3'd1,
        C_CHAN     = 3'd2,
        C_PAUSE    = 3'd3,
        C_PLAY     = 3'd4,
        C_OFF      = 3'd5
    } cmd_t;

    localparam logic [7:0] CMD_BOOT_ALL = 8'h64; // "d"
    localparam logic [7:0] CMD_PAUSE    = 8'h73; // "s"
    localparam logic [7:0] CMD_PLAY     = 8'h70; // "p"
    localparam logic [7:0] CMD_OFF      = 8'h78; // "x"
    localparam logic [7:0] CMD_DIGIT0   = 8'h30; // "0"

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tdc_cmd_decode.sv
// Combinational decode of one UART byte into a command type and channel index.
// Digits beyond the configured channel count decode as C_CHAN with idx_valid=0.
module tdc_cmd_decode
    import tdc_ctrl_pkg::*;
#(
    parameter int NUM_TDC = 2
) (
    input  logic [7:0] rx_data,
    output cmd_t       cmd_type,
    output logic [2:0] ch_idx,
    output logic       idx_valid
);

    logic is_digit;

    always_comb begin
        cmd_type  = C_NONE;
        ch_idx    = 3'd0;
        idx_valid = 1'b0;
        is_digit  = (rx_data >= CMD_DIGIT0) && (rx_data <= (CMD_DIGIT0 + 8'd7));

        if (is_digit) begin
            cmd_type  = C_CHAN;
            ch_idx    = rx_data[2:0]; // "0" is 0x30, so the low bits are the index
            idx_valid = (32'(ch_idx) < NUM_TDC);
        end else begin
            case (rx_data)
                CMD_BOOT_ALL: cmd_type = C_BOOT_ALL;
                CMD_PAUSE:    cmd_type = C_PAUSE;
                CMD_PLAY:     cmd_type = C_PLAY;
                CMD_OFF:      cmd_type = C_OFF;
                default:      cmd_type = C_NONE;
            endcase
        end
    end

endmodule

// File: rtl/tdc_ctrl_seq.sv
// UART-command driven power-up sequencer for NUM_TDC converters:
// enable low, boot wait, soft-reset pulse, with pause flag and status pulses.
module tdc_ctrl_seq
    import tdc_ctrl_pkg::*;
#(
    parameter int NUM_TDC          = 2,
    parameter int LOW_CYCLES       = 16,
    parameter int BOOT_CYCLES      = 1048576,
    parameter int RST_PULSE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               new_rx_data,
    output logic [NUM_TDC-1:0] tdc_enable,
    output logic [NUM_TDC-1:0] soft_reset,
    output logic               pause,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
);

    localparam int CNT_W = $clog2(max3(LOW_CYCLES, BOOT_CYCLES, RST_PULSE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_CYCLES);
    localparam logic [CNT_W-1:0] BOOT_C  = CNT_W'(BOOT_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(RST_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_TDC-1:0] mask_q, mask_d;
    logic [NUM_TDC-1:0] en_q, en_d;
    logic [NUM_TDC-1:0] sr_q, sr_d;
    logic               pause_q, pause_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    cmd_t       dec_type;
    logic [2:0] dec_idx;
    logic       dec_valid;
    cmd_t       cmd;
    logic       seq_cmd;

    tdc_cmd_decode #(.NUM_TDC(NUM_TDC)) u_dec (
        .rx_data   (rx_data),
        .cmd_type  (dec_type),
        .ch_idx    (dec_idx),
        .idx_valid (dec_valid)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        en_d    = en_q;
        sr_d    = sr_q;
        pause_d = pause_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        cmd     = new_rx_data ? dec_type : C_NONE;
        seq_cmd = (cmd == C_BOOT_ALL) || (cmd == C_CHAN) || (cmd == C_OFF);

        // Pause/play are orthogonal to the sequence and never touch it.
        if (cmd == C_PAUSE) pause_d = 1'b1;
        if (cmd == C_PLAY)  pause_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd == C_BOOT_ALL || (cmd == C_CHAN && dec_valid)) begin
                    mask_d  = (cmd == C_BOOT_ALL) ? {NUM_TDC{1'b1}}
                                                  : (NUM_TDC'(1) << dec_idx);
                    en_d    = en_q & ~mask_d;
                    cnt_d   = CNT_ONE;
                    busy_d  = 1'b1;
                    state_d = EN_LOW;
                end else if (cmd == C_CHAN) begin
                    err_d = 1'b1;
                end else if (cmd == C_OFF) begin
                    en_d = '0;
                end
            end
            EN_LOW: begin
                err_d = seq_cmd;
                if (cnt_q == LOW_C) begin
                    en_d    = en_q | mask_q;
                    cnt_d   = CNT_ONE;
                    state_d = EN_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            EN_HIGH: begin
                err_d = seq_cmd;
                if (cnt_q == BOOT_C) begin
                    sr_d    = mask_q;
                    cnt_d   = CNT_ONE;
                    state_d = SRST;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SRST: begin
                err_d = seq_cmd;
                if (cnt_q == PULSE_C) begin
                    sr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                sr_d    = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            en_q    <= '0;
            sr_q    <= '0;
            pause_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            sr_q    <= sr_d;
            pause_q <= pause_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tdc_enable = en_q;
    assign soft_reset = sr_q;
    assign pause      = pause_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cmd_err    = err_q;

endmodule

// File: doc/tdc_ctrl_seq.md
Name: tdc_ctrl_seq

Overview:
Parametrised successor of the UART-driven TDC power-up controller. It decodes single-byte commands from the UART receiver and sequences enable-low, boot wait and soft-reset for NUM_TDC converters, either all together or one at a time. It also provides a global pause/play flag, busy/done status and a rejected-command pulse. It sits between the UART rx path and the TDC front-end/readout blocks.

Parameters:
NUM_TDC, 2, number of TDC channels (1..8)
LOW_CYCLES, 16, cycles tdc_enable is held low before rising (>=1)
BOOT_CYCLES, 1048576, cycles waited after enable rises before soft reset (>=1)
RST_PULSE_CYCLES, 4, soft_reset pulse width in cycles (>=1)
CNT_W, derived localparam, clog2(max(LOW_CYCLES,BOOT_CYCLES,RST_PULSE_CYCLES)+1)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
rx_data  in  8  received UART byte
new_rx_data  in  1  one-cycle strobe, rx_data valid
tdc_enable  out  NUM_TDC  per-channel TDC ENABLE pin
soft_reset  out  NUM_TDC  per-channel soft-reset request, registered
pause  out  1  1 = readout paused
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of a sequence
cmd_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- All outputs registered. Reset values: tdc_enable=0, soft_reset=0, pause=0, busy=0, done=0, cmd_err=0; state=IDLE, counter=0, target mask=0.
- A command is accepted only when new_rx_data=1 at a rising edge. Outputs respond at that same edge.
- Command set:
  - "d": target all channels.
  - "0".."7": target channel n. If n>=NUM_TDC, pulse cmd_err and leave state unchanged.
  - "s": pause=1.
  - "p": pause=0.
  - "x": all tdc_enable=0.
  - Any other byte is ignored with no cmd_err.
- "s" and "p" are accepted in every state and never disturb a running sequence.
- "d", digits and "x" are accepted only in IDLE. In any other state they pulse cmd_err and change nothing else.
- States: IDLE -> EN_LOW -> EN_HIGH -> SRST -> IDLE.
  - IDLE to EN_LOW: on "d" or a valid digit. Latch target mask, drive targeted tdc_enable bits 0, counter=1, busy=1.
  - EN_LOW: targeted enable bits stay 0. After LOW_CYCLES cycles in EN_LOW, drive targeted bits 1, counter=1, go to EN_HIGH.
  - EN_HIGH: wait BOOT_CYCLES cycles, then drive targeted soft_reset bits 1, counter=1, go to SRST.
  - SRST: hold soft_reset for RST_PULSE_CYCLES cycles. Then clear soft_reset, busy=0, done=1 for one cycle, go to IDLE.
  - Illegal state encoding: go to IDLE with soft_reset=0.
- Timing for a command accepted at edge k:
  - enable falls at k.
  - enable rises at k+LOW_CYCLES.
  - soft_reset is high over [k+LOW+BOOT, k+LOW+BOOT+PULSE).
  - busy falls and done pulses at k+LOW+BOOT+PULSE.
- Non-targeted channels keep their tdc_enable value and never see soft_reset.
- The counter compares equal to the cycle parameter. It must not wrap, and it must be wide enough for BOOT_CYCLES=2^20.
- Reset mid-sequence: everything returns to reset values on the next edge. soft_reset is never left high.
- "x" in IDLE clears every enable bit and leaves pause unchanged.

Decomposition:
- Shared package tdc_ctrl_pkg:
  - state enum (IDLE, EN_LOW, EN_HIGH, SRST)
  - command byte constants CMD_BOOT_ALL="d", CMD_PAUSE="s", CMD_PLAY="p", CMD_OFF="x", CMD_DIGIT0="0"
- One natural sub-module, tdc_cmd_decode: combinational byte to {cmd_type, channel index, index_valid}. The FSM, counter and output registers stay in tdc_ctrl_seq.

Test Plan:
(Bench uses NUM_TDC=2, LOW=4, BOOT=10, PULSE=2.)
1. rst held 3 cycles, then released -> all outputs 0, busy=0, no spurious soft_reset for 50 cycles.
2. "d" at edge 0 -> tdc_enable=00 over edges 0-3, 11 from edge 4. soft_reset=11 at edges 14-15, 00 at edge 16. busy=0 and done=1 at edge 16 only.
3. After test 2, send "1" -> only bit1 drops and re-rises, soft_reset=10 only, channel 0 enable stays 1. Then send "5" -> cmd_err pulse, no state change.
4. "d" sent, then "0" at edge 6 and "s" at edge 8 -> cmd_err pulse at edge 6, pause=1 from edge 8, sequence timing identical to test 2.
5. "d" sent, rst asserted at edge 14 (during SRST) -> at edge 15 soft_reset=00, tdc_enable=00, busy=0, pause=0, no done pulse.
6. "p" then "x" then byte 0x41 -> pause=0, tdc_enable=00, no cmd_err for 0x41, busy stays 0.
